// File: rtl/seg_msg_pkg.sv
// Shared types and glyph data for the seven-segment message sequencer.
package seg_msg_pkg;

  // Sequencer FSM states; the encoding is also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Segment patterns: bit 7 = dp, bits 6..0 = a,b,c,d,e,f,g, active-high.
  localparam logic [7:0] GLYPH_DP    = 8'h80;
  localparam logic [7:0] GLYPH_S     = 8'h5B;
  localparam logic [7:0] GLYPH_E     = 8'h4F;
  localparam logic [7:0] GLYPH_N     = 8'h15;
  localparam logic [7:0] GLYPH_O     = 8'h7E;
  localparam logic [7:0] GLYPH_L     = 8'h0E;
  localparam logic [7:0] GLYPH_G     = 8'h5F;
  localparam logic [7:0] GLYPH_U     = 8'h3E;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  // Number of glyphs actually stored in the message ROM.
  localparam int ROM_DEPTH = 14;

  // Message ROM. Entries at or beyond msg_len, or beyond the stored
  // message, read as blank.
  function automatic logic [7:0] glyph_lookup(input logic [3:0] idx,
                                              input int msg_len);
    logic [7:0] g;
    g = GLYPH_BLANK;
    if (int'(idx) < msg_len) begin
      case (idx)
        4'd0:    g = GLYPH_DP;
        4'd1:    g = GLYPH_S;
        4'd2:    g = GLYPH_E;
        4'd3:    g = GLYPH_N;
        4'd4:    g = GLYPH_O;
        4'd5:    g = GLYPH_L;
        4'd6:    g = GLYPH_G;
        4'd7:    g = GLYPH_U;
        4'd8:    g = GLYPH_L;
        4'd9:    g = GLYPH_G;
        4'd10:   g = GLYPH_O;
        4'd11:   g = GLYPH_N;
        4'd12:   g = GLYPH_U;
        4'd13:   g = GLYPH_L;
        default: g = GLYPH_BLANK;
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchronizer, stable-count debounce and a
// rising-edge detector producing a single-cycle step request per press.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic step_req
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_deb;
  logic          r_deb_q;
  logic [CW-1:0] r_cnt;

  // Synchronize the raw button, then accept a new level only after it has
  // disagreed with the debounced level for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= btn_raw;
      r_sync1 <= r_sync0;
      if (r_sync1 != r_deb) begin
        if (r_cnt == CNT_LAST) begin
          r_deb <= r_sync1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_deb_q <= 1'b0;
    else     r_deb_q <= r_deb;
  end

  assign step_req = r_deb & ~r_deb_q;

endmodule

// File: rtl/seg_msg_sequencer.sv
// Steps a glyph message onto the segment pins, advancing on a debounced
// button press or an internal prescaler tick, with a blank gap before
// every new glyph after the first.
module seg_msg_sequencer
  import seg_msg_pkg::*;
#(
  parameter int MSG_LEN    = 14,
  parameter int DEB_CYCLES = 250000,
  parameter int TICK_DIV   = 5000000,
  parameter int BLANK_CYC  = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       mode_auto,
  input  logic       hold,
  output logic [7:0] seg,
  output logic [3:0] index,
  output logic       wrap,
  output logic       blanking,
  output logic [1:0] dbg_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [3:0]    IDX_LAST   = 4'(MSG_LEN - 1);

  logic          w_step_req;
  logic          w_tick;
  logic          w_adv;
  logic [3:0]    w_next_index;
  logic [7:0]    w_glyph;

  logic [TW-1:0] r_pcnt;
  logic [BW-1:0] r_bcnt;
  state_t        r_state;
  logic [7:0]    r_seg;
  logic [3:0]    r_index;
  logic          r_wrap;
  logic          r_blanking;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .step_req (w_step_req)
  );

  // Prescaler: runs only in auto mode, freezes under hold, clears in manual.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (!mode_auto) begin
      r_pcnt <= '0;
    end else if (!hold) begin
      r_pcnt <= (r_pcnt == TICK_LAST) ? '0 : r_pcnt + TW'(1);
    end
  end

  assign w_tick       = mode_auto & ~hold & (r_pcnt == TICK_LAST);
  assign w_adv        = (mode_auto ? w_tick : w_step_req) & ~hold;
  assign w_next_index = (r_index == IDX_LAST) ? 4'd0 : r_index + 4'd1;
  assign w_glyph      = glyph_lookup(r_index, MSG_LEN);

  // Display FSM with registered outputs; advances arriving in BLANK are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_seg      <= GLYPH_BLANK;
      r_index    <= 4'd0;
      r_wrap     <= 1'b0;
      r_blanking <= 1'b0;
      r_bcnt     <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_seg      <= GLYPH_BLANK;
          r_blanking <= 1'b0;
          if (w_adv) begin
            r_state <= ST_SHOW;
            r_seg   <= w_glyph;
          end
        end
        ST_SHOW: begin
          if (w_adv) begin
            r_state    <= ST_BLANK;
            r_seg      <= GLYPH_BLANK;
            r_blanking <= 1'b1;
            r_index    <= w_next_index;
            r_wrap     <= (w_next_index == 4'd0);
            r_bcnt     <= '0;
          end
        end
        ST_BLANK: begin
          if (r_bcnt == BLANK_LAST) begin
            r_state    <= ST_SHOW;
            r_seg      <= w_glyph;
            r_blanking <= 1'b0;
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_seg      <= GLYPH_BLANK;
          r_blanking <= 1'b0;
        end
      endcase
    end
  end

  assign seg       = r_seg;
  assign index     = r_index;
  assign wrap      = r_wrap;
  assign blanking  = r_blanking;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Directed bench for seg_msg_sequencer with small timing parameters.
module tb_seg_msg_sequencer;
  import seg_msg_pkg::*;

  localparam int DEB   = 4;
  localparam int TDIV  = 8;
  localparam int BLANK = 2;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       mode_auto;
  logic       hold;
  logic [7:0] seg;
  logic [3:0] index;
  logic       wrap;
  logic       blanking;
  logic [1:0] dbg_state;

  int checks;
  int errors;

  typedef struct {
    logic       btn;
    int         cyc;
    logic [7:0] seg;
    logic [3:0] idx;
    logic       blank;
  } vec_t;

  vec_t       man_tbl[8];
  logic [7:0] exp_rom[14];

  seg_msg_sequencer #(
    .MSG_LEN    (14),
    .DEB_CYCLES (DEB),
    .TICK_DIV   (TDIV),
    .BLANK_CYC  (BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .mode_auto (mode_auto),
    .hold      (hold),
    .seg       (seg),
    .index     (index),
    .wrap      (wrap),
    .blanking  (blanking),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock, then settle 2 time units past the edge before sampling/driving.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_seg, input logic [3:0] e_idx,
                         input logic e_blank, input logic e_wrap);
    chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
    chk({tag, ".index"}, 32'(index), 32'(e_idx));
    chk({tag, ".blanking"}, 32'(blanking), 32'(e_blank));
    chk({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
  endtask

  initial begin
    int wrap_cnt;
    int k;
    checks = 0;
    errors = 0;

    exp_rom = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
                8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};

    // Manual-mode press sequence: btn level, cycles held, expected outputs after.
    man_tbl[0] = '{btn: 1'b1, cyc: 6,  seg: 8'h00, idx: 4'd0, blank: 1'b0};
    man_tbl[1] = '{btn: 1'b1, cyc: 1,  seg: 8'h80, idx: 4'd0, blank: 1'b0};
    man_tbl[2] = '{btn: 1'b1, cyc: 3,  seg: 8'h80, idx: 4'd0, blank: 1'b0};
    man_tbl[3] = '{btn: 1'b0, cyc: 10, seg: 8'h80, idx: 4'd0, blank: 1'b0};
    man_tbl[4] = '{btn: 1'b1, cyc: 7,  seg: 8'h00, idx: 4'd1, blank: 1'b1};
    man_tbl[5] = '{btn: 1'b1, cyc: 1,  seg: 8'h00, idx: 4'd1, blank: 1'b1};
    man_tbl[6] = '{btn: 1'b1, cyc: 1,  seg: 8'h5B, idx: 4'd1, blank: 1'b0};
    man_tbl[7] = '{btn: 1'b0, cyc: 10, seg: 8'h5B, idx: 4'd1, blank: 1'b0};

    rst       = 1'b1;
    btn_raw   = 1'b0;
    mode_auto = 1'b0;
    hold      = 1'b0;
    step(3);
    chk_out("reset", 8'h00, 4'd0, 1'b0, 1'b0);
    chk("reset.state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk_out("idle", 8'h00, 4'd0, 1'b0, 1'b0);
    end

    // Table-driven manual presses.
    for (int i = 0; i < 8; i++) begin
      btn_raw = man_tbl[i].btn;
      step(man_tbl[i].cyc);
      chk_out($sformatf("man%0d", i), man_tbl[i].seg, man_tbl[i].idx, man_tbl[i].blank, 1'b0);
    end

    // Bounce: 2 high, 2 low, repeated, never stable for DEB cycles.
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0);
      step(2);
      chk_out("bounce", 8'h5B, 4'd1, 1'b0, 1'b0);
    end
    btn_raw = 1'b0;
    step(10);
    chk_out("bounce_end", 8'h5B, 4'd1, 1'b0, 1'b0);

    // Fresh start in auto mode: a full message cycle plus wrap.
    rst = 1'b1;
    step(1);
    rst       = 1'b0;
    mode_auto = 1'b1;
    wrap_cnt  = 0;
    for (int s = 1; s <= 122; s++) begin
      step(1);
      if (wrap === 1'b1) wrap_cnt++;
      if (s % 8 == 0) begin
        k = s / 8;
        if (k == 1) chk_out("auto_first", 8'h80, 4'd0, 1'b0, 1'b0);
        else        chk_out($sformatf("auto_gap%0d", k), 8'h00, 4'((k - 1) % 14), 1'b1, k == 15);
      end else if (s % 8 == 2 && s >= 18) begin
        k = (s - 2) / 8;
        chk_out($sformatf("auto_show%0d", k), exp_rom[(k - 1) % 14], 4'((k - 1) % 14), 1'b0, 1'b0);
      end
    end
    chk("auto.wrap_count", 32'(wrap_cnt), 32'd1);

    // Hold freezes display and prescaler (prescaler count is 2 here).
    hold = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      chk_out("hold", 8'h80, 4'd0, 1'b0, 1'b0);
    end
    hold = 1'b0;
    step(5);
    chk_out("resume_pre", 8'h80, 4'd0, 1'b0, 1'b0);
    step(1);
    chk_out("resume_adv", 8'h00, 4'd1, 1'b1, 1'b0);

    // Hold raised in BLANK: gap still completes into SHOW.
    hold = 1'b1;
    step(2);
    chk_out("hold_blank", 8'h5B, 4'd1, 1'b0, 1'b0);
    chk("hold_blank.state", 32'(dbg_state), 32'(ST_SHOW));
    hold = 1'b0;
    step(7);
    chk_out("pre_gap", 8'h5B, 4'd1, 1'b0, 1'b0);
    step(1);
    chk_out("in_gap", 8'h00, 4'd2, 1'b1, 1'b0);

    // Asynchronous reset between edges while blanking.
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 8'h00, 4'd0, 1'b0, 1'b0);
    chk("async_rst.state", 32'(dbg_state), 32'(ST_IDLE));
    mode_auto = 1'b0;
    #1;
    rst = 1'b0;

    // From IDLE a press shows glyph 0 directly, no gap.
    btn_raw = 1'b1;
    step(6);
    chk_out("post_rst_pre", 8'h00, 4'd0, 1'b0, 1'b0);
    step(1);
    chk_out("post_rst_show", 8'h80, 4'd0, 1'b0, 1'b0);
    btn_raw = 1'b0;
    step(10);
    chk_out("post_rst_rel", 8'h80, 4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_msg_sequencer.md
# seg_msg_sequencer

Controller that sequences the 14-entry seven-segment message glyph ROM onto the display pins. It advances through the message in two ways: manually from a debounced push button, or automatically from an internal prescaler tick. Each new glyph is preceded by a blanking gap so that consecutive identical glyphs stay distinguishable. It sits between the raw board inputs (`ui_in`) and the segment outputs (`uo_out`) in the top-level wrapper.

## Interface
Parameters:
- `MSG_LEN`, 14: number of glyphs in the message; the index wraps from `MSG_LEN-1` to 0. Legal range 2..16.
- `DEB_CYCLES`, 250000: consecutive stable cycles required before the debounced button level changes.
- `TICK_DIV`, 5000000: clock cycles per auto-advance tick.
- `BLANK_CYC`, 1250000: length of the blanking gap in cycles. Must be ≥1.

Ports:
- `clk`  in  1  system clock. The only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_raw`  in  1  raw step button. Asynchronous and bouncing.
- `mode_auto`  in  1  1 = advance on prescaler tick; 0 = advance on button press.
- `hold`  in  1  1 = freeze the sequence; advance events are dropped.
- `seg`  out  8  segment drive. Bit 7 = dp, bits 6..0 = a,b,c,d,e,f,g. Active-high. Registered.
- `index`  out  4  index of the glyph currently shown (or about to be shown). Registered.
- `wrap`  out  1  one-cycle pulse when the index wraps to 0.
- `blanking`  out  1  high while in the BLANK state.

## Operation
- Reset values: `seg`=0x00, `index`=0, `wrap`=0, `blanking`=0, FSM=IDLE. Synchronizer, debounce and prescaler registers are all cleared.
- Button path:
  - 2-FF synchronizer on `btn_raw`.
  - Debounce counter: the debounced level takes the synchronized value once that value has differed from it for `DEB_CYCLES` consecutive cycles.
  - A rising edge of the debounced level produces a one-cycle `step_req`.
- Prescaler:
  - Counts 0..`TICK_DIV-1` only while `mode_auto`=1 and `hold`=0.
  - `tick` is a one-cycle pulse on the cycle the counter reaches `TICK_DIV-1`; the counter then returns to 0.
  - Cleared while `mode_auto`=0. Frozen, not cleared, while `hold`=1.
- Advance event: `adv` = (`mode_auto` ? `tick` : `step_req`) & ~`hold`.
- FSM:
  - IDLE: `seg`=0x00. On `adv` → SHOW, `seg`=glyph(`index`), where `index`=0 after reset.
  - SHOW: `seg`=glyph(`index`). On `adv` → BLANK, `seg`=0x00, `blanking`=1, `index` := next, where next = (`index`==`MSG_LEN-1`) ? 0 : `index`+1. `wrap` pulses in the same cycle that `index` becomes 0 by wrapping.
  - BLANK: counts `BLANK_CYC` cycles, then → SHOW with `seg`=glyph(`index`). `adv` events arriving during BLANK are dropped, not queued.
- Glyph ROM (combinational, indexed by `index`): 0:0x80, 1:0x5B, 2:0x4F, 3:0x15, 4:0x7E, 5:0x0E, 6:0x5F, 7:0x3E, 8:0x0E, 9:0x5F, 10:0x7E, 11:0x15, 12:0x3E, 13:0x0E. Index ≥ `MSG_LEN` or >13 returns 0x00.
- Mode switch mid-sequence: FSM state and `index` are kept; only the advance source changes. Switching during BLANK does not shorten the gap.
- `hold` asserted during BLANK: the gap still completes and the FSM rests in SHOW.
- Reset asserted mid-operation (any state): all outputs go to their reset values immediately, without waiting for a clock edge.

## Timing
- `btn_raw` rises cleanly at edge t: synchronizer adds 2 cycles, debounce adds `DEB_CYCLES`, and `step_req` is asserted in cycle t+2+`DEB_CYCLES`.
- `adv` in cycle c (from SHOW): `seg`=0x00 and the new `index` are visible after edge c+1. The new glyph appears after edge c+1+`BLANK_CYC`.
- From IDLE: glyph 0 is visible after edge c+1, with no gap.
- Auto mode, steady state: one glyph change per `TICK_DIV` cycles, provided `TICK_DIV` > `BLANK_CYC`. Otherwise ticks that land in BLANK are dropped.
- A button bounce shorter than `DEB_CYCLES` produces no `step_req`. Holding the button produces exactly one `step_req`.

## Structure
- Shared package `seg_msg_pkg`:
  - FSM state enum {IDLE, SHOW, BLANK}.
  - Glyph constants (GLYPH_DP, GLYPH_S, GLYPH_E, GLYPH_N, GLYPH_O, GLYPH_L, GLYPH_G, GLYPH_U, GLYPH_BLANK).
  - The message glyph ROM contents.
- One sub-module, `btn_debounce`: synchronizer + debounce counter + rising-edge detector. Output `step_req`. Parameter `DEB_CYCLES`.
- Prescaler, FSM, index counter and ROM lookup live in `seg_msg_sequencer`.

## Test plan
All scenarios use parameters `DEB_CYCLES`=4, `TICK_DIV`=8, `BLANK_CYC`=2.
- Reset, then idle for 50 cycles → `seg`=0x00, `index`=0, `wrap`=0, `blanking`=0 throughout.
- Manual mode: clean press of 10 cycles → exactly one `step_req`; `seg`=0x80 (glyph 0). Second press → `seg`=0x00 for 2 cycles, then 0x5B, `index`=1.
- Bounce: `btn_raw` toggles every 2 cycles for 20 cycles, then held low → no `step_req`, and `seg`/`index` unchanged.
- Auto mode with `mode_auto`=1 for 14×8+8 cycles → glyph sequence 0x80, 0x5B, …, 0x0E, then 0x80 again. `wrap` pulses once, when `index` goes 13→0.
- `hold`=1 for 40 cycles in auto mode → no change on `seg`/`index`. After `hold` is released, the prescaler resumes from its frozen count.
- Assert `rst` asynchronously mid-BLANK (between clock edges) → `seg`=0x00, `index`=0, `blanking`=0 before the next edge. After release, the FSM is in IDLE.
